blk_mem_gen_0: RTL and testbench
================================

Name: blk_mem_gen_0

Overview:
- Simple dual-port block RAM: port A is write-only with per-byte write enables, port B is read-only with a registered output.
- Used as a scratch or packet buffer behind byte-addressed bus masters in the design_1 block design.
- One clock drives both ports. Asynchronous active-low reset clears the read output only; memory contents are never reset.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 1024, number of DATA_W-bit words; must be a power of two.
- ADDR_W, 32, width of addra and addrb. Addresses are byte addresses.
- INIT_VAL, 0, value of every word at simulation time zero.

Ports:
- clka, in, 1, the single clock for both ports; all logic is on its rising edge.
- rstb, in, 1, asynchronous active-low reset.
- ena, in, 1, port A enable; writes occur only when ena=1.
- wea, in, DATA_W/8, per-byte write enable; bit i writes dina[8i+7:8i].
- addra, in, ADDR_W, port A byte address.
- dina, in, DATA_W, port A write data.
- enb, in, 1, port B enable.
- addrb, in, ADDR_W, port B byte address.
- doutb, out, DATA_W, port B read data, registered.

Behaviour:
- Word index is addr[log2(DATA_W/8) +: log2(DEPTH)].
  - Byte-offset bits [1:0] are ignored, so unaligned addresses alias to the containing word.
  - Upper bits are ignored, so out-of-range addresses wrap modulo DEPTH.
- Write: on a rising clka edge with rstb=1, ena=1 and wea[i]=1, byte i of mem[idx(addra)] is set to byte i of dina.
  - Bytes with wea[i]=0 are unchanged.
  - wea=0 or ena=0 means no write.
- Write during reset: while rstb=0, writes are suppressed (gated synchronously).
- Read: on a rising clka edge with rstb=1 and enb=1, doutb is loaded with mem[idx(addrb)]. Read latency is 1 clock.
  - With enb=0, doutb holds its value.
- Collision: a read and a write to the same word in the same edge is read-first. doutb gets the old contents; the new data is visible on the next read.
- Reset: rstb=0 forces doutb to 0 immediately (asynchronous), including mid-read. doutb stays 0 while rstb=0.
  - The first read edge after deassertion returns valid data.
  - Memory contents survive reset.
- Power-up: all words are INIT_VAL; doutb is 0 until the first read.
- No handshakes; every enabled cycle is accepted. There is no backpressure and no error signalling.

Optional Feature:
- Macro: BLK_MEM_OUTREG_EN.
- Defined: an extra output register stage is added after the RAM read register. Read latency becomes 2 clocks.
  - The output stage advances only when enb was 1 on the preceding edge.
  - rstb=0 clears both stages asynchronously.
- Not defined: 1-clock latency as described in Behaviour.

Decomposition:
- Package blk_mem_gen_pkg holds:
  - default constants for DATA_W, DEPTH and ADDR_W;
  - localparam helpers BYTES = DATA_W/8, OFFS_W = log2(BYTES), IDX_W = log2(DEPTH);
  - the function addr_to_idx.
- One sub-module, blk_mem_gen_0_ram, holds the storage array, the byte-enable write and the read-first synchronous read.
- The top level holds address decode, reset gating, the output register and the optional OUTREG stage.

Test Plan:
- Reset: rstb=0 with doutb previously nonzero -> doutb=0 without a clock edge. Release rstb=1 -> doutb stays 0 until a read.
- Full write and read: ena=1, wea=4'hF, addra=0x20, dina=0xDEADFACE. Next cycle enb=1, addrb=0x20 -> doutb=0xDEADFACE one edge later (two edges with BLK_MEM_OUTREG_EN).
- Byte enables: after the previous write, wea=4'b0011, dina=0x12345678 at 0x20 -> read 0x20 returns 0xDEAD5678.
- Collision: in the same edge, write 0xCAFEBABE to 0x20 and read 0x20 -> doutb=0xDEAD5678. The next read returns 0xCAFEBABE.
- Aliasing and wrap: read addrb=0x23 and then 0x1020 (DEPTH=1024) -> both return the contents of word 8 (0xCAFEBABE).
- Enable gating:
  - enb=0 while addrb changes -> doutb holds.
  - ena=0 with wea=4'hF writes nothing; a following read shows the old value.
  - A write issued while rstb=0 is not stored.

Source files
------------

// File: rtl/blk_mem_gen_pkg.sv
// Shared constants and address-decode helper for the blk_mem_gen_0 block RAM.
package blk_mem_gen_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_BYTES  = DEF_DATA_W / 8;
    localparam int DEF_OFFS_W = $clog2(DEF_BYTES);
    localparam int DEF_IDX_W  = $clog2(DEF_DEPTH);

    // Byte address -> word index: drop the byte-offset bits, wrap modulo DEPTH.
    function automatic logic [31:0] addr_to_idx(input logic [63:0] addr,
                                                input int          offs_w,
                                                input int          idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((addr >> offs_w) & mask);
    endfunction

endpackage

// File: rtl/blk_mem_gen_0_ram.sv
// Storage array with per-byte write and read-first registered read.
module blk_mem_gen_0_ram #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter int                IDX_W    = 10,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [IDX_W-1:0]    widx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [IDX_W-1:0]    ridx,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (we && wbe[i]) begin
                mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Non-blocking read of mem in the same edge as the write gives read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/blk_mem_gen_0.sv
// Simple dual-port block RAM: write-only port A with byte enables, read-only port B.
// Define BLK_MEM_OUTREG_EN to add a second output register (2-clock read latency).
module blk_mem_gen_0
    import blk_mem_gen_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clka,
    input  logic                rstb,
    input  logic                ena,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dina,
    input  logic                enb,
    input  logic [ADDR_W-1:0]   addrb,
    output logic [DATA_W-1:0]   doutb
);

    localparam int BYTES  = DATA_W / 8;
    localparam int OFFS_W = $clog2(BYTES);
    localparam int IDX_W  = $clog2(DEPTH);

    // No handshake: every edge with ena=1 (or enb=1) is accepted unconditionally.
    logic [IDX_W-1:0]  widx;
    logic [IDX_W-1:0]  ridx;
    logic              we;
    logic [DATA_W-1:0] rdata;

    assign widx = IDX_W'(addr_to_idx(64'(addra), OFFS_W, IDX_W));
    assign ridx = IDX_W'(addr_to_idx(64'(addrb), OFFS_W, IDX_W));
    // Writes are suppressed while reset is asserted; contents themselves never reset.
    assign we   = ena && rstb;

    blk_mem_gen_0_ram #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W),
        .INIT_VAL(INIT_VAL)
    ) u_ram (
        .clk  (clka),
        .rst_n(rstb),
        .we   (we),
        .wbe  (wea),
        .widx (widx),
        .wdata(dina),
        .re   (enb),
        .ridx (ridx),
        .rdata(rdata)
    );

`ifdef BLK_MEM_OUTREG_EN
    logic              re_d;
    logic [DATA_W-1:0] dout_q;

    // Second stage only advances when the first stage was loaded on the previous edge.
    always_ff @(posedge clka or negedge rstb) begin
        if (!rstb) begin
            re_d   <= 1'b0;
            dout_q <= '0;
        end else begin
            re_d <= enb;
            if (re_d) begin
                dout_q <= rdata;
            end
        end
    end

    assign doutb = dout_q;
`else
    assign doutb = rdata;
`endif

endmodule

// File: tb/tb_blk_mem_gen_0.sv
// Directed self-checking bench for blk_mem_gen_0 (default and BLK_MEM_OUTREG_EN builds).
module tb_blk_mem_gen_0;

`ifdef BLK_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clka;
    logic        rstb;
    logic        ena;
    logic [3:0]  wea;
    logic [31:0] addra;
    logic [31:0] dina;
    logic        enb;
    logic [31:0] addrb;
    logic [31:0] doutb;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    blk_mem_gen_0 dut (
        .clka (clka),
        .rstb (rstb),
        .ena  (ena),
        .wea  (wea),
        .addra(addra),
        .dina (dina),
        .enb  (enb),
        .addrb(addrb),
        .doutb(doutb)
    );

    // Clock / reset
    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial begin
        #200000;
        $display("FAIL timeout doutb=%08h", doutb);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        ena = 1'b1; wea = be; addra = a; dina = d;
        tick();
        ena = 1'b0; wea = '0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        enb = 1'b1; addrb = a;
        tick();
        enb = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        check(tag, doutb, exp_q.pop_front());
    endtask

    initial begin
        checks = 0; errors = 0;
        rstb = 1'b0; ena = 1'b0; wea = '0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;
        repeat (3) tick();
        check("reset_dout", doutb, 32'h0);
        rstb = 1'b1;
        tick(); tick();
        check("post_reset_idle", doutb, 32'h0);

        do_write(32'h20, 32'hDEADFACE, 4'hF);
        do_read("full_rw", 32'h20, 32'hDEADFACE);

        do_write(32'h20, 32'h12345678, 4'b0011);
        do_read("byte_en", 32'h20, 32'hDEAD5678);

        // Same-edge write and read of word 8: old data must come back.
        ena = 1'b1; wea = 4'hF; addra = 32'h20; dina = 32'hCAFEBABE;
        enb = 1'b1; addrb = 32'h20;
        tick();
        ena = 1'b0; wea = '0; enb = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        check("collision_old", doutb, 32'hDEAD5678);
        do_read("collision_new", 32'h20, 32'hCAFEBABE);

        do_write(32'h40, 32'h11112222, 4'hF);
        do_read("alias_unaligned", 32'h23, 32'hCAFEBABE);
        do_read("alias_wrap", 32'h1020, 32'hCAFEBABE);

        enb = 1'b0; addrb = 32'h40;
        repeat (3) tick();
        check("enb_hold", doutb, 32'hCAFEBABE);
        do_read("read_word16", 32'h40, 32'h11112222);

        ena = 1'b0; wea = 4'hF; addra = 32'h20; dina = 32'hBAD0BAD0;
        tick();
        wea = '0;
        do_read("ena_gate", 32'h20, 32'hCAFEBABE);

        do_write(32'h1044, 32'h55AA55AA, 4'hF);
        do_read("write_wrap", 32'h44, 32'h55AA55AA);
        do_read("init_val", 32'h80, 32'h0);
        do_read("reread_wrap", 32'h44, 32'h55AA55AA);

        // Asynchronous reset with nonzero output, then a write and read attempted during reset.
        rstb = 1'b0;
        #1;
        check("async_reset", doutb, 32'h0);
        ena = 1'b1; wea = 4'hF; addra = 32'h20; dina = 32'h0BADF00D;
        enb = 1'b1; addrb = 32'h40;
        tick(); tick();
        check("reset_hold", doutb, 32'h0);
        ena = 1'b0; wea = '0; enb = 1'b0;
        rstb = 1'b1;
        tick(); tick();
        check("release_idle", doutb, 32'h0);
        do_read("write_in_reset", 32'h20, 32'hCAFEBABE);
        do_read("mem_survives", 32'h40, 32'h11112222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
